// File: rtl/instr_l1_refill_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_l1_refill_if
//  Description : Bundle of the refill engine's fetch-side, memory-side and
//                L1-write-side signals. The master modport is the refill
//                engine; the slave modport is its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_l1_refill_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  // Fetch side
  logic                  miss_valid;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  busy;
  logic                  done;
  // Next-level memory read channel
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // L1 line-write port
  logic                  l1_we;
  logic [ADDR_WIDTH-1:0] l1_addr;
  logic [DATA_WIDTH-1:0] l1_data;

  modport master (
    input  miss_valid, miss_addr, mem_ready, mem_rvalid, mem_rdata,
    output busy, done, mem_req, mem_addr, l1_we, l1_addr, l1_data
  );

  modport slave (
    output miss_valid, miss_addr, mem_ready, mem_rvalid, mem_rdata,
    input  busy, done, mem_req, mem_addr, l1_we, l1_addr, l1_data
  );
endinterface
`default_nettype wire

// File: rtl/instr_l1_refill.sv
`default_nettype none
// ============================================================================
//  Module      : instr_l1_refill
//  Description : Instruction L1 line-fill engine. On a miss it requests every
//                word of the line (word 0 first) from the next memory level
//                and writes each in-order response into the L1, pulsing done
//                together with the last write.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_l1_refill #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int OFFSET_WIDTH   = 5,
  parameter int WORDS_PER_LINE = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,   // asynchronous, active-low
  instr_l1_refill_if.master   rf
);

  localparam int LINE_W = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int CNT_W  = $clog2(WORDS_PER_LINE) + 1;

  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] c_WORDS    = CNT_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [LINE_W-1:0]     r_line;
  logic [CNT_W-1:0]      r_req_cnt;
  logic [CNT_W-1:0]      r_rsp_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_l1_we;
  logic [ADDR_WIDTH-1:0] r_l1_addr;
  logic [DATA_WIDTH-1:0] r_l1_data;

  // Word offset bits of the miss address never matter: fills start at word 0.
  wire logic w_unused_offset = ^rf.miss_addr[OFFSET_WIDTH-1:0];

  // A response is taken only during a fill and only until the line is complete.
  wire logic w_rsp_take = (r_state != S_IDLE) && rf.mem_rvalid && (r_rsp_cnt != c_WORDS);

  // Word address inside the current line; the counter is zero-extended into
  // the offset field so offset bits above the word index stay zero.
  function automatic logic [ADDR_WIDTH-1:0] f_word_addr(input logic [LINE_W-1:0] line,
                                                        input logic [CNT_W-1:0]  idx);
    return {line, OFFSET_WIDTH'(idx)};
  endfunction

  // Fill sequencer: request issue, response capture into the L1 write port,
  // and completion. All outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_line     <= '0;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_l1_we    <= 1'b0;
      r_l1_addr  <= '0;
      r_l1_data  <= '0;
    end else begin
      r_l1_we <= 1'b0;
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (rf.miss_valid) begin
            r_line     <= rf.miss_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_busy     <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_addr <= f_word_addr(rf.miss_addr[ADDR_WIDTH-1:OFFSET_WIDTH], '0);
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          // Request and address hold until the memory accepts them.
          if (r_mem_req && rf.mem_ready) begin
            r_req_cnt <= r_req_cnt + c_ONE;
            if (r_req_cnt == c_LAST_IDX) begin
              r_mem_req <= 1'b0;
              r_state   <= S_WAIT;
            end else begin
              r_mem_addr <= f_word_addr(r_line, r_req_cnt + c_ONE);
            end
          end
        end
        S_WAIT: begin
        end
        default: r_state <= S_IDLE;
      endcase

      // Responses arrive in request order, so rsp_cnt names the word.
      if (w_rsp_take) begin
        r_l1_we   <= 1'b1;
        r_l1_addr <= f_word_addr(r_line, r_rsp_cnt);
        r_l1_data <= rf.mem_rdata;
        r_rsp_cnt <= r_rsp_cnt + c_ONE;
        if (r_rsp_cnt == c_LAST_IDX) begin
          r_done <= 1'b1;
        end
      end

      // The final write cycle ends the fill; busy covers that write.
      if (r_done) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_mem_req <= 1'b0;
      end
    end
  end

  assign rf.busy     = r_busy;
  assign rf.done     = r_done;
  assign rf.mem_req  = r_mem_req;
  assign rf.mem_addr = r_mem_addr;
  assign rf.l1_we    = r_l1_we;
  assign rf.l1_addr  = r_l1_addr;
  assign rf.l1_data  = r_l1_data;

endmodule
`default_nettype wire

// File: tb/tb_instr_l1_refill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_l1_refill
//  Description : Directed bench for instr_l1_refill with an in-order memory
//                model and an L1 shadow array fed from the L1 write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_l1_refill;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  instr_l1_refill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_l1_refill #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_WIDTH(5), .WORDS_PER_LINE(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Controls written by the main sequence only.
  int lat_mode = 0;   // 0: latency 1, 1: random 1..5
  int rdy_mode = 0;   // 0: ready always, 1: ready pattern 1,0,0
  bit stray_go = 1'b0;

  // State written by the memory/monitor process only.
  int              cyc      = 0;
  int              hs_n     = 0;
  int              wr_n     = 0;
  int              last_due = 0;
  logic [AW-1:0]   q_addr[$];
  int              q_due[$];
  logic [AW-1:0]   wr_addr[$];
  logic [DW-1:0]   wr_data[$];
  logic [DW-1:0]   l1m [0:(1<<AW)-1];
  bit              l1v [0:(1<<AW)-1];

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return 32'hFFFF_FFFF - 32'(a);
  endfunction

  // Memory model and L1 shadow, acting on the falling edge.
  initial begin
    int due;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.l1_we === 1'b1) begin
        wr_addr.push_back(bus.l1_addr);
        wr_data.push_back(bus.l1_data);
        l1m[bus.l1_addr] = bus.l1_data;
        l1v[bus.l1_addr] = 1'b1;
        wr_n++;
      end
      if (!reset) begin
        q_addr.delete();
        q_due.delete();
        last_due       = 0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end else begin
        bus.mem_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        if (bus.mem_req === 1'b1 && bus.mem_ready) begin
          due = cyc + ((lat_mode != 0) ? int'($urandom_range(1, 5)) : 1);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          q_addr.push_back(bus.mem_addr);
          q_due.push_back(due);
          hs_n++;
        end
        if (stray_go) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'hDEAD_BEEF;
        end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mdata(q_addr.pop_front());
          void'(q_due.pop_front());
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = '0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),     0);
    chk({tag, "_done"},   32'(bus.done),     0);
    chk({tag, "_req"},    32'(bus.mem_req),  0);
    chk({tag, "_maddr"},  32'(bus.mem_addr), 0);
    chk({tag, "_we"},     32'(bus.l1_we),    0);
    chk({tag, "_l1addr"}, 32'(bus.l1_addr),  0);
    chk({tag, "_l1data"}, bus.l1_data,       0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.done), 1);
  endtask

  task automatic chk_line(input string tag, input int base_w, input int base_a);
    chk({tag, "_nwr"}, wr_n - base_w, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[base_w + k]), base_a + k);
      chk($sformatf("%s_data%0d", tag, k), wr_data[base_w + k], 32'hFFFF_FFFF - base_a - k);
    end
  endtask

  initial begin
    int bw, bh, n, gap, bad;
    logic [AW-1:0] pa;
    logic [AW-1:0] na;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;

    // Reset state
    repeat (3) step();
    chk_zero("rst");
    reset = 1'b1;
    step();

    // Basic fill of 0x0123: requests 1-8, writes 3-10, done 10, idle 11
    bus.miss_addr  = 14'h0123;
    bus.miss_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      bus.miss_valid = 1'b0;
      chk($sformatf("t1_busy_c%0d", c), 32'(bus.busy),    32'(c <= 10));
      chk($sformatf("t1_done_c%0d", c), 32'(bus.done),    32'(c == 10));
      chk($sformatf("t1_req_c%0d", c),  32'(bus.mem_req), 32'(c <= 8));
      chk($sformatf("t1_we_c%0d", c),   32'(bus.l1_we),   32'(c >= 3 && c <= 10));
      if (c <= 8)
        chk($sformatf("t1_maddr_c%0d", c), 32'(bus.mem_addr), 32'h120 + c - 1);
      if (c >= 3 && c <= 10) begin
        chk($sformatf("t1_l1addr_c%0d", c), 32'(bus.l1_addr), 32'h120 + c - 3);
        chk($sformatf("t1_l1data_c%0d", c), bus.l1_data, 32'hFFFF_FEDF - (c - 3));
      end
    end

    // Backpressure: ready 1,0,0 pattern, line 0x0A40
    rdy_mode = 1;
    bw = wr_n;
    bh = hs_n;
    bus.miss_addr  = 14'h0A47;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.mem_req === 1'b1 && bus.mem_ready === 1'b0) begin
        pa = bus.mem_addr;
        step();
        chk("t2_hold_req",  32'(bus.mem_req),  1);
        chk("t2_hold_addr", 32'(bus.mem_addr), 32'(pa));
      end else begin
        step();
      end
      n++;
    end
    chk("t2_done", 32'(bus.done), 1);
    step();
    chk("t2_nhs", hs_n - bh, 8);
    chk_line("t2", bw, 32'h0A40);
    rdy_mode = 0;

    // Variable latency 1..5, line 0x2A40
    lat_mode = 1;
    bw = wr_n;
    gap = 0;
    bus.miss_addr  = 14'h2A5F;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      if (bus.busy !== 1'b1) gap++;
      step();
      n++;
    end
    chk("t3_done", 32'(bus.done), 1);
    chk("t3_busy_gap", gap, 0);
    step();
    chk_line("t3", bw, 32'h2A40);
    lat_mode = 0;

    // Miss while busy, then a stray response while idle
    bw = wr_n;
    bus.miss_addr  = 14'h0300;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    step();
    bus.miss_addr  = 14'h3FE0;
    bus.miss_valid = 1'b1;
    repeat (4) step();
    bus.miss_valid = 1'b0;
    wait_done("t4_done");
    step();
    chk("t4_idle_busy", 32'(bus.busy),    0);
    step();
    chk("t4_idle_req",  32'(bus.mem_req), 0);
    chk_line("t4", bw, 32'h0300);
    bad = 0;
    for (int k = bw; k < wr_n; k++)
      if (wr_addr[k][13:5] == 9'h1FF) bad++;
    chk("t4_no_line_1ff", bad, 0);
    bw = wr_n;
    stray_go = 1'b1;
    step();
    stray_go = 1'b0;
    step();
    chk("t4_stray_we",   32'(bus.l1_we), 0);
    chk("t4_stray_busy", 32'(bus.busy),  0);
    step();
    chk("t4_stray_nwr", wr_n - bw, 0);

    // Reset after the third write, then a clean fill of 0x0040
    bw = wr_n;
    bus.miss_addr  = 14'h0123;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    n = 0;
    while (wr_n - bw < 3 && n < 100) begin
      step();
      n++;
    end
    chk("t5_third_write", wr_n - bw, 3);
    #2 reset = 1'b0;
    #1;
    chk_zero("t5_async");
    step();
    step();
    reset = 1'b1;
    step();
    bw = wr_n;
    bus.miss_addr  = 14'h0040;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    wait_done("t5_done");
    step();
    chk_line("t5", bw, 32'h0040);

    // Back-to-back fills of all 512 lines in order i*377 mod 512
    bus.miss_addr  = '0;
    bus.miss_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      wait_done($sformatf("t6_done_%0d", i));
      na = AW'(((i + 1) * 377) % 512) << 5;
      if (i < 511) bus.miss_addr = na;
      else         bus.miss_valid = 1'b0;
      step();
      chk($sformatf("t6_gap_busy_%0d", i), 32'(bus.busy), 0);
      if (i < 511) begin
        step();
        chk($sformatf("t6_start_req_%0d", i),  32'(bus.mem_req),  1);
        chk($sformatf("t6_start_addr_%0d", i), 32'(bus.mem_addr), 32'(na));
      end
    end
    step();
    for (int ln = 0; ln < 512; ln++) begin
      bad = 0;
      for (int w = 0; w < 8; w++) begin
        pa = AW'((ln << 5) | w);
        if (!l1v[pa] || l1m[pa] !== mdata(pa)) bad++;
      end
      chk($sformatf("t6_readback_line_%0d", ln), bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
